// File: rtl/linear_layer_seq.sv
// Time-multiplexed linear layer: a single signed MAC walks every (row, col) weight,
// finishing one output element every NIN cycles, with valid/ready on both vectors.
module linear_layer_seq #(
    parameter int WIDTH = 16,
    parameter int NIN   = 4,
    parameter int NOUT  = 4,
    parameter int FRAC  = 0,
    parameter logic [WIDTH*NIN*NOUT-1:0] WEIGHTS_MATRIX_FLAT = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_vec [0:NIN-1],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_vec [0:NOUT-1],
    output logic                    busy
);

    localparam int PROD_W = 2 * WIDTH;
    localparam int ACC_W  = PROD_W + $clog2(NIN);
    localparam int COL_W  = (NIN > 1) ? $clog2(NIN) : 1;
    localparam int ROW_W  = (NOUT > 1) ? $clog2(NOUT) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NIN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NOUT - 1);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;

    logic [ROW_W-1:0]        row_q, row_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [WIDTH-1:0] in_reg_q  [0:NIN-1];
    logic signed [WIDTH-1:0] in_reg_d  [0:NIN-1];
    logic signed [WIDTH-1:0] out_vec_q [0:NOUT-1];
    logic signed [WIDTH-1:0] out_vec_d [0:NOUT-1];

    logic signed [WIDTH-1:0]  w_mat [0:NOUT-1][0:NIN-1];
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  acc_shift;
    logic signed [WIDTH-1:0]  sat_val;
    logic                     last_mac;

    // Row r starts at the top of its NIN*WIDTH slice; element 0 sits at the slice MSB.
    for (genvar r = 0; r < NOUT; r++) begin : g_row
        for (genvar i = 0; i < NIN; i++) begin : g_col
            assign w_mat[r][i] = WEIGHTS_MATRIX_FLAT[NIN*(NOUT-r)*WIDTH-1 - i*WIDTH -: WIDTH];
        end
    end

    assign last_mac = (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_mac)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            RUN:  busy     = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // The sum includes this cycle's product, so on the last column it is the finished dot product.
    always_comb begin
        prod      = PROD_W'(in_reg_q[col_q]) * PROD_W'(w_mat[row_q][col_q]);
        acc_sum   = acc_q + ACC_W'(prod);
        acc_shift = acc_sum >>> FRAC;
        if (acc_shift > ACC_MAX) begin
            sat_val = OUT_MAX;
        end else if (acc_shift < ACC_MIN) begin
            sat_val = OUT_MIN;
        end else begin
            sat_val = acc_shift[WIDTH-1:0];
        end
    end

    always_comb begin
        row_d     = row_q;
        col_d     = col_q;
        acc_d     = acc_q;
        in_reg_d  = in_reg_q;
        out_vec_d = out_vec_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    in_reg_d = in_vec;
                    row_d    = '0;
                    col_d    = '0;
                    acc_d    = '0;
                end
            end
            RUN: begin
                if (col_q == COL_LAST) begin
                    out_vec_d[row_q] = sat_val;
                    acc_d            = '0;
                    col_d            = '0;
                    row_d            = last_mac ? '0 : row_q + ROW_W'(1);
                end else begin
                    acc_d = acc_sum;
                    col_d = col_q + COL_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q     <= '0;
            col_q     <= '0;
            acc_q     <= '0;
            in_reg_q  <= '{default: '0};
            out_vec_q <= '{default: '0};
        end else begin
            row_q     <= row_d;
            col_q     <= col_d;
            acc_q     <= acc_d;
            in_reg_q  <= in_reg_d;
            out_vec_q <= out_vec_d;
        end
    end

    assign out_vec = out_vec_q;

endmodule
